// File: rtl/fir_input_sequencer.sv
// Upstream sequencer for the FIR stage: buffers samples in a small FIFO, loads
// coefficient sets and pushes samples through the load_coeff/data_ready handshakes.
module fir_input_sequencer #(
    parameter int NUM_COEFFS = 4,
    parameter int DEPTH      = 4,
    parameter int HS_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic                     new_coeff_set,
    input  logic [16*NUM_COEFFS-1:0] coeff_in,
    input  logic [15:0]              sample_in,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    input  logic                     modwait,
    input  logic [15:0]              fir_out,
    input  logic                     err,
    output logic [15:0]              sample_data,
    output logic [15:0]              fir_coefficient,
    output logic                     data_ready,
    output logic                     load_coeff,
    output logic [15:0]              result,
    output logic                     result_err,
    output logic                     result_valid,
    output logic                     coeff_loaded,
    output logic                     hs_timeout
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (NUM_COEFFS > 1) ? $clog2(NUM_COEFFS) : 1;
    localparam int TW = $clog2(HS_TIMEOUT + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_COEFFS - 1);
    localparam logic [TW-1:0] LAST_TICK  = TW'(HS_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, C_ASSERT, C_WAIT, S_ASSERT, S_WAIT, CAPTURE} state_t;

    state_t                   state_q, state_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [TW-1:0]            tmo_q, tmo_d;
    logic                     coeff_loaded_q, coeff_loaded_d;
    logic                     pop, start_load, capture, timeout, push;

    logic [15:0]              mem_q [DEPTH];
    logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]            count_q;

    logic [16*NUM_COEFFS-1:0] req_q, coeff_q;
    logic                     pending_q;
    logic [15:0]              coeff_word [NUM_COEFFS];

    logic [15:0]              sample_data_q, result_q;
    logic                     result_err_q, result_valid_q, hs_timeout_q;
    logic                     data_ready_q, load_coeff_q;

    assign sample_ready = (count_q != FULL_COUNT);
    assign push         = sample_valid && sample_ready;

    // NOTE: the sample storage carries no reset; occupancy lives in count_q and
    // the pointers, so an entry is never read before it has been written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= sample_in;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // A request is parked in req_q and only copied into coeff_q when a load
    // starts, so the coefficient on the bus never changes mid-load.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            req_q     <= '0;
            coeff_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            if (new_coeff_set) req_q   <= coeff_in;
            if (start_load)    coeff_q <= req_q;
            if (new_coeff_set)   pending_q <= 1'b1;
            else if (start_load) pending_q <= 1'b0;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_COEFFS; k++) coeff_word[k] = coeff_q[16*k +: 16];
    end

    // NOTE: every combinational output gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        tmo_d          = tmo_q;
        coeff_loaded_d = coeff_loaded_q;
        pop            = 1'b0;
        start_load     = 1'b0;
        capture        = 1'b0;
        timeout        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pending_q) begin
                    state_d        = C_ASSERT;
                    idx_d          = '0;
                    tmo_d          = '0;
                    coeff_loaded_d = 1'b0;
                    start_load     = 1'b1;
                end else if (coeff_loaded_q && count_q != '0) begin
                    state_d = S_ASSERT;
                    tmo_d   = '0;
                    pop     = 1'b1;
                end
            end
            C_ASSERT, S_ASSERT: begin
                if (modwait) begin
                    state_d = (state_q == C_ASSERT) ? C_WAIT : S_WAIT;
                end else if (tmo_q == LAST_TICK) begin
                    state_d = IDLE;
                    timeout = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            C_WAIT: begin
                if (!modwait) begin
                    if (idx_q == LAST_IDX) begin
                        coeff_loaded_d = 1'b1;
                        state_d        = IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        tmo_d   = '0;
                        state_d = C_ASSERT;
                    end
                end
            end
            S_WAIT: begin
                if (!modwait) begin
                    state_d = CAPTURE;
                    capture = 1'b1;
                end
            end
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            tmo_q          <= '0;
            coeff_loaded_q <= 1'b0;
            data_ready_q   <= 1'b0;
            load_coeff_q   <= 1'b0;
            result_valid_q <= 1'b0;
            hs_timeout_q   <= 1'b0;
            sample_data_q  <= '0;
            result_q       <= '0;
            result_err_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            tmo_q          <= tmo_d;
            coeff_loaded_q <= coeff_loaded_d;
            data_ready_q   <= (state_d == S_ASSERT);
            load_coeff_q   <= (state_d == C_ASSERT);
            result_valid_q <= capture;
            hs_timeout_q   <= timeout;
            if (pop) sample_data_q <= mem_q[rd_ptr_q];
            // The result is taken as modwait falls, so it is already valid
            // during the CAPTURE cycle in which result_valid is high.
            if (capture) begin
                result_q     <= fir_out;
                result_err_q <= err;
            end
        end
    end

    assign sample_data     = sample_data_q;
    assign fir_coefficient = coeff_word[idx_q];
    assign data_ready      = data_ready_q;
    assign load_coeff      = load_coeff_q;
    assign result          = result_q;
    assign result_err      = result_err_q;
    assign result_valid    = result_valid_q;
    assign coeff_loaded    = coeff_loaded_q;
    assign hs_timeout      = hs_timeout_q;

endmodule

// File: tb/tb_fir_input_sequencer.sv
// Directed bench for fir_input_sequencer: a reset/FIFO vector table, then
// hand-written handshake sequences against a small filter model.
module tb_fir_input_sequencer;
    localparam int NC    = 4;
    localparam int DEPTH = 4;
    localparam int HST   = 16;
    localparam logic [1:0] K_S = 2'd0;
    localparam logic [1:0] K_C = 2'd1;
    localparam logic [1:0] K_R = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] val;
        logic        er;
    } ev_t;

    typedef struct {
        logic           rst_n;
        logic           ncs;
        logic [16*NC-1:0] coeff;
        logic [15:0]    smp;
        logic           sv;
        logic           mw;
        logic           er;
        logic [6:0]     exp_flags;
        logic [15:0]    exp_sd;
    } vec_t;

    typedef enum logic [1:0] {M_NONE, M_NORMAL, M_HOLD} mode_t;

    logic             clk = 1'b0;
    logic             n_reset = 1'b0;
    logic             new_coeff_set = 1'b0;
    logic [16*NC-1:0] coeff_in = '0;
    logic [15:0]      sample_in = '0;
    logic             sample_valid = 1'b0;
    logic             modwait, err;
    logic [15:0]      fir_out;
    logic             sample_ready, data_ready, load_coeff, result_err;
    logic             result_valid, coeff_loaded, hs_timeout;
    logic [15:0]      sample_data, fir_coefficient, result;

    logic             tbl_active = 1'b1;
    logic             tbl_mw = 1'b0;
    logic             tbl_err = 1'b0;
    logic             mdl_mw = 1'b0;
    logic             mdl_err = 1'b0;
    logic [15:0]      mdl_fir = '0;
    mode_t            mode = M_NONE;

    ev_t              ev_q[$];
    ev_t              exp_q[$];
    int               n_tmo = 0;
    int               checks = 0;
    int               errors = 0;

    assign modwait = tbl_active ? tbl_mw : mdl_mw;
    assign err     = tbl_active ? tbl_err : mdl_err;
    assign fir_out = mdl_fir;

    always #5 clk = ~clk;

    fir_input_sequencer #(.NUM_COEFFS(NC), .DEPTH(DEPTH), .HS_TIMEOUT(HST)) dut (
        .clk(clk), .n_reset(n_reset), .new_coeff_set(new_coeff_set), .coeff_in(coeff_in),
        .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .modwait(modwait), .fir_out(fir_out), .err(err), .sample_data(sample_data),
        .fir_coefficient(fir_coefficient), .data_ready(data_ready), .load_coeff(load_coeff),
        .result(result), .result_err(result_err), .result_valid(result_valid),
        .coeff_loaded(coeff_loaded), .hs_timeout(hs_timeout)
    );

    function automatic ev_t mk(input logic [1:0] k, input logic [15:0] v, input logic e);
        ev_t x;
        x.kind = k;
        x.val  = v;
        x.er   = e;
        return x;
    endfunction

    // Filter model: modwait rises 3 cycles after a strobe, stays high 2 cycles
    // (or until released in hold mode); fir_out = sample + 1.
    initial begin : filter_model
        forever begin
            @(negedge clk);
            if (mode != M_NONE && (data_ready || load_coeff)) begin
                if (data_ready) begin
                    mdl_fir = sample_data + 16'd1;
                    mdl_err = (sample_data == 16'hE11E);
                end
                repeat (2) @(negedge clk);
                mdl_mw = 1'b1;
                if (mode == M_HOLD) begin
                    while (mode == M_HOLD) @(negedge clk);
                end else begin
                    repeat (2) @(negedge clk);
                end
                mdl_mw = 1'b0;
            end
        end
    end

    initial begin : monitor
        logic dr_prev, lc_prev;
        dr_prev = 1'b0;
        lc_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (data_ready && !dr_prev) ev_q.push_back(mk(K_S, sample_data, 1'b0));
            if (load_coeff && !lc_prev) ev_q.push_back(mk(K_C, fir_coefficient, 1'b0));
            if (result_valid)           ev_q.push_back(mk(K_R, result, result_err));
            if (hs_timeout)             n_tmo++;
            dr_prev = data_ready;
            lc_prev = load_coeff;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] v);
        sample_in    = v;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic request(input logic [16*NC-1:0] c);
        coeff_in      = c;
        new_coeff_set = 1'b1;
        @(negedge clk);
        new_coeff_set = 1'b0;
        coeff_in      = '1;
    endtask

    function automatic int count_kind(input int base, input logic [1:0] k);
        int n = 0;
        for (int i = base; i < ev_q.size(); i++) if (ev_q[i].kind == k) n++;
        return n;
    endfunction

    task automatic wait_kind(input string name, input int base, input logic [1:0] k,
                             input int n, input int budget);
        int t = 0;
        while (count_kind(base, k) < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        check({name, " events arrived"}, 32'(count_kind(base, k) >= n), 32'd1);
        repeat (20) @(negedge clk);
    endtask

    task automatic expect_ev(input logic [1:0] k, input logic [15:0] v, input logic e);
        exp_q.push_back(mk(k, v, e));
    endtask

    task automatic check_seq(input string name, input int base);
        check({name, " event count"}, 32'(ev_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < ev_q.size())
                check($sformatf("%s event %0d", name, i), 32'(ev_q[base+i]), 32'(exp_q[i]));
        end
        exp_q.delete();
    endtask

    initial begin : main
        vec_t vecs [11];
        int   base, t, tmo0;

        // flags = {sample_ready, data_ready, load_coeff, result_valid, coeff_loaded, hs_timeout, result_err}
        vecs[0]  = '{1'b0, 1'b1, 64'hDEAD_BEEF_0123_4567, 16'h5555, 1'b1, 1'b1, 1'b1, 7'b1000000, 16'h0};
        vecs[1]  = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, 7'b1000000, 16'h0};
        vecs[2]  = '{1'b0, 1'b1, 64'h0, 16'h0000, 1'b0, 1'b1, 1'b0, 7'b1000000, 16'h0};
        vecs[3]  = '{1'b0, 1'b1, 64'h0004_0003_0002_0001, 16'h1234, 1'b1, 1'b1, 1'b1, 7'b1000000, 16'h0};
        vecs[4]  = '{1'b1, 1'b0, 64'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 7'b1000000, 16'h0};
        vecs[5]  = '{1'b1, 1'b0, 64'h0, 16'hA5A5, 1'b1, 1'b0, 1'b0, 7'b1000000, 16'h0};
        vecs[6]  = '{1'b1, 1'b0, 64'h0, 16'h5A5A, 1'b1, 1'b0, 1'b0, 7'b1000000, 16'h0};
        vecs[7]  = '{1'b1, 1'b0, 64'h0, 16'h1111, 1'b1, 1'b0, 1'b0, 7'b1000000, 16'h0};
        vecs[8]  = '{1'b1, 1'b0, 64'h0, 16'h2222, 1'b1, 1'b0, 1'b0, 7'b0000000, 16'h0};
        vecs[9]  = '{1'b1, 1'b0, 64'h0, 16'h3333, 1'b1, 1'b0, 1'b0, 7'b0000000, 16'h0};
        vecs[10] = '{1'b1, 1'b0, 64'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 7'b0000000, 16'h0};

        // Reset with busy inputs, then pushes with no coefficients loaded.
        for (int i = 0; i < 11; i++) begin
            n_reset       = vecs[i].rst_n;
            new_coeff_set = vecs[i].ncs;
            coeff_in      = vecs[i].coeff;
            sample_in     = vecs[i].smp;
            sample_valid  = vecs[i].sv;
            tbl_mw        = vecs[i].mw;
            tbl_err       = vecs[i].er;
            @(negedge clk);
            check($sformatf("vec%0d flags", i),
                  {25'd0, sample_ready, data_ready, load_coeff, result_valid,
                   coeff_loaded, hs_timeout, result_err}, {25'd0, vecs[i].exp_flags});
            check($sformatf("vec%0d sample_data", i), {16'd0, sample_data}, {16'd0, vecs[i].exp_sd});
            check($sformatf("vec%0d fir_coefficient", i), {16'd0, fir_coefficient}, 32'd0);
            check($sformatf("vec%0d result", i), {16'd0, result}, 32'd0);
        end

        // Reset again: FIFO must come back empty.
        new_coeff_set = 1'b0;
        sample_valid  = 1'b0;
        tbl_active    = 1'b0;
        n_reset       = 1'b0;
        @(negedge clk);
        check("reset clears full FIFO", {31'd0, sample_ready}, 32'd1);
        n_reset = 1'b1;
        @(negedge clk);

        // Coefficient load.
        mode = M_NORMAL;
        base = ev_q.size();
        request({16'h0004, 16'h0003, 16'h0002, 16'h0001});
        check("coeff_loaded low before load", {31'd0, coeff_loaded}, 32'd0);
        t = 0;
        while (!coeff_loaded && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("coeff_loaded after load", {31'd0, coeff_loaded}, 32'd1);
        check("coeff strobes at coeff_loaded", 32'(count_kind(base, K_C)), 32'd4);
        repeat (5) @(negedge clk);
        for (int k = 1; k <= 4; k++) expect_ev(K_C, 16'(k), 1'b0);
        check_seq("coeff load", base);

        // Sample flow in FIFO order.
        base = ev_q.size();
        tmo0 = n_tmo;
        push(16'h1234);
        push(16'h0010);
        push(16'h8000);
        wait_kind("sample flow", base, K_R, 3, 400);
        expect_ev(K_S, 16'h1234, 1'b0); expect_ev(K_R, 16'h1235, 1'b0);
        expect_ev(K_S, 16'h0010, 1'b0); expect_ev(K_R, 16'h0011, 1'b0);
        expect_ev(K_S, 16'h8000, 1'b0); expect_ev(K_R, 16'h8001, 1'b0);
        check_seq("sample flow", base);
        check("no timeout in sample flow", 32'(n_tmo - tmo0), 32'd0);

        // FIFO full while the filter holds modwait high.
        mode = M_HOLD;
        base = ev_q.size();
        push(16'h0F00);
        t = 0;
        while (!mdl_mw && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("filter busy before fill", {31'd0, mdl_mw}, 32'd1);
        for (int i = 0; i <= DEPTH; i++) begin
            check($sformatf("sample_ready before push %0d", i), {31'd0, sample_ready},
                  32'(i < DEPTH));
            push(16'hA000 + 16'(i));
        end
        check("sample_ready low when full", {31'd0, sample_ready}, 32'd0);
        check("data_ready low in S_WAIT", {31'd0, data_ready}, 32'd0);
        mode = M_NORMAL;
        wait_kind("fifo drain", base, K_R, 5, 600);
        expect_ev(K_S, 16'h0F00, 1'b0); expect_ev(K_R, 16'h0F01, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            expect_ev(K_S, 16'hA000 + 16'(i), 1'b0);
            expect_ev(K_R, 16'hA001 + 16'(i), 1'b0);
        end
        check_seq("fifo full", base);

        // Coefficient request during S_WAIT with two samples queued.
        base = ev_q.size();
        push(16'h0B00);
        push(16'hE11E);
        push(16'h0B02);
        t = 0;
        while (!(count_kind(base, K_S) >= 1 && mdl_mw) && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("first sample in S_WAIT", {31'd0, mdl_mw}, 32'd1);
        request({16'h0008, 16'h0007, 16'h0006, 16'h0005});
        wait_kind("priority", base, K_R, 3, 800);
        expect_ev(K_S, 16'h0B00, 1'b0); expect_ev(K_R, 16'h0B01, 1'b0);
        for (int k = 5; k <= 8; k++) expect_ev(K_C, 16'(k), 1'b0);
        expect_ev(K_S, 16'hE11E, 1'b0); expect_ev(K_R, 16'hE11F, 1'b1);
        expect_ev(K_S, 16'h0B02, 1'b0); expect_ev(K_R, 16'h0B03, 1'b0);
        check_seq("priority", base);
        check("coeff_loaded after reload", {31'd0, coeff_loaded}, 32'd1);

        // Sample handshake timeout.
        mode = M_NONE;
        base = ev_q.size();
        tmo0 = n_tmo;
        push(16'h0C00);
        push(16'h0C01);
        t = 0;
        while (!data_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        t = 0;
        while (data_ready && t < 40) begin
            t++;
            @(negedge clk);
        end
        check("data_ready cycles before timeout", 32'(t), 32'(HST));
        check("hs_timeout pulse", {31'd0, hs_timeout}, 32'd1);
        check("no result on timeout", {31'd0, result_valid}, 32'd0);
        mode = M_NORMAL;
        @(negedge clk);
        check("hs_timeout one cycle", {31'd0, hs_timeout}, 32'd0);
        check("next sample serviced", {31'd0, data_ready}, 32'd1);
        wait_kind("sample timeout", base, K_R, 1, 200);
        expect_ev(K_S, 16'h0C00, 1'b0);
        expect_ev(K_S, 16'h0C01, 1'b0); expect_ev(K_R, 16'h0C02, 1'b0);
        check_seq("sample timeout", base);
        check("one timeout pulse", 32'(n_tmo - tmo0), 32'd1);

        // Coefficient handshake timeout: set must be re-requested.
        mode = M_NONE;
        base = ev_q.size();
        tmo0 = n_tmo;
        request({16'h0044, 16'h0033, 16'h0022, 16'h0011});
        t = 0;
        while (!hs_timeout && t < 60) begin
            @(negedge clk);
            t++;
        end
        check("coeff timeout pulse", {31'd0, hs_timeout}, 32'd1);
        check("load_coeff dropped", {31'd0, load_coeff}, 32'd0);
        check("coeff_loaded low after timeout", {31'd0, coeff_loaded}, 32'd0);
        push(16'h0D00);
        repeat (10) @(negedge clk);
        check("no sample without coeffs", 32'(count_kind(base, K_S)), 32'd0);
        mode = M_NORMAL;
        request({16'h0044, 16'h0033, 16'h0022, 16'h0011});
        wait_kind("coeff timeout", base, K_R, 1, 400);
        expect_ev(K_C, 16'h0011, 1'b0);
        expect_ev(K_C, 16'h0011, 1'b0); expect_ev(K_C, 16'h0022, 1'b0);
        expect_ev(K_C, 16'h0033, 1'b0); expect_ev(K_C, 16'h0044, 1'b0);
        expect_ev(K_S, 16'h0D00, 1'b0); expect_ev(K_R, 16'h0D01, 1'b0);
        check_seq("coeff timeout", base);
        check("coeff timeout count", 32'(n_tmo - tmo0), 32'd1);

        // Reset in the middle of a sample transaction.
        mode = M_HOLD;
        base = ev_q.size();
        push(16'h0E00);
        t = 0;
        while (!mdl_mw && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("mid-transaction busy", {31'd0, mdl_mw}, 32'd1);
        n_reset = 1'b0;
        @(negedge clk);
        check("mid reset flags",
              {25'd0, sample_ready, data_ready, load_coeff, result_valid,
               coeff_loaded, hs_timeout, result_err}, 32'h40);
        check("mid reset sample_data", {16'd0, sample_data}, 32'd0);
        mode    = M_NONE;
        n_reset = 1'b1;
        repeat (20) @(negedge clk);
        check("no result after abort", 32'(count_kind(base, K_R)), 32'd0);
        check("coeff_loaded cleared by reset", {31'd0, coeff_loaded}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_input_sequencer.md
Name: fir_input_sequencer

Overview:
- Upstream driver for the FIR filter stage.
- Buffers incoming audio samples in a small FIFO and loads a coefficient set into the filter via the load_coeff/modwait handshake.
- Pushes samples one at a time via the data_ready/modwait handshake, then captures fir_out/err as a one-cycle result strobe for the downstream consumer.

Parameters:
- NUM_COEFFS, 4, number of 16-bit coefficients per set.
- DEPTH, 4, sample FIFO depth (power of 2, >=2).
- HS_TIMEOUT, 16, max cycles to wait for modwait to rise after a strobe is asserted.

Ports:
- clk  in  1  system clock
- n_reset  in  1  asynchronous active-low reset
- new_coeff_set  in  1  one-cycle request to (re)load coefficients from coeff_in
- coeff_in  in  16*NUM_COEFFS  coefficient set; coeff k at bits [16k+15:16k]
- sample_in  in  16  incoming sample
- sample_valid  in  1  sample_in valid
- sample_ready  out  1  FIFO can accept (= !full)
- modwait  in  1  filter busy flag
- fir_out  in  16  filter result
- err  in  1  filter error flag
- sample_data  out  16  sample to filter
- fir_coefficient  out  16  coefficient to filter
- data_ready  out  1  sample strobe to filter
- load_coeff  out  1  coefficient strobe to filter
- result  out  16  captured fir_out
- result_err  out  1  captured err
- result_valid  out  1  one-cycle pulse, result/result_err valid
- coeff_loaded  out  1  a complete set is loaded in the filter
- hs_timeout  out  1  one-cycle pulse on handshake timeout

Behaviour:
- Reset (async, n_reset=0): all outputs 0, except sample_ready=1.
- Reset effects: FIFO empty, FSM IDLE, coeff pending flag 0, coeff index 0, timeout counter 0.
- Reset mid-transaction aborts it; no result is produced.
- Coefficient request:
  - new_coeff_set=1 latches coeff_in into an internal register and sets pending.
  - Requests arriving during a coefficient load or sample transaction stay pending. The latest coeff_in wins.
  - The new set loads after the current transaction completes.
- FIFO:
  - Push when sample_valid && sample_ready.
  - Push while full is ignored. sample_ready is low then, so no data is lost.
  - Simultaneous push and pop when not full is allowed; count is unchanged.
  - Pointers wrap modulo DEPTH.
  - Pop occurs on the IDLE->S_ASSERT transition; the popped value is registered onto sample_data.
- FSM states and transitions:
  - IDLE:
    - If pending: go to C_ASSERT, index=0, clear pending, coeff_loaded=0.
    - Else if coeff_loaded && FIFO not empty: go to S_ASSERT (pop).
    - Coefficient loads take priority over samples.
  - C_ASSERT:
    - load_coeff=1; fir_coefficient=coeff_reg[index], stable for the whole state.
    - When modwait=1, go to C_WAIT.
  - C_WAIT:
    - load_coeff=0. When modwait=0: if index==NUM_COEFFS-1, set coeff_loaded=1 and go to IDLE; else index++ and go to C_ASSERT.
  - S_ASSERT:
    - data_ready=1; sample_data held. When modwait=1, go to S_WAIT.
  - S_WAIT:
    - data_ready=0. When modwait=0, go to CAPTURE.
  - CAPTURE:
    - result<=fir_out, result_err<=err, result_valid=1 for exactly this cycle, then go to IDLE.
    - result and result_err hold until the next capture.
- Handshake latency:
  - The filter synchronises strobes through 2 flops, so modwait rises no earlier than 2 cycles after the strobe rises.
  - The strobe is held until modwait is seen high; the FSM never deasserts early.
- Timeout:
  - The counter resets on entry to C_ASSERT/S_ASSERT and increments each cycle in those states.
  - If it reaches HS_TIMEOUT with modwait still 0:
    - Deassert the strobe, pulse hs_timeout for 1 cycle, go to IDLE.
    - In C_ASSERT, coeff_loaded stays 0; the set must be re-requested.
    - In S_ASSERT, the sample is discarded and no result is produced.
- Waits for modwait to fall have no timeout.
- Minimum sample transaction: IDLE, S_ASSERT (>=3 cycles), S_WAIT (>=1), CAPTURE (1).
- Outputs data_ready, load_coeff, result_valid and hs_timeout are driven from registered state; they are glitch-free.

Test Plan:
- Reset: hold n_reset=0 with random inputs -> all outputs 0, sample_ready=1. Release, then push a sample with no coefficients loaded -> data_ready stays 0.
- Coefficient load: coeff_in={16'h0004,16'h0003,16'h0002,16'h0001}, pulse new_coeff_set, model modwait rising 3 cycles after each strobe and high for 2 cycles. Expected:
  - load_coeff pulses 4 times, with fir_coefficient 0001,0002,0003,0004 in order.
  - coeff_loaded=1 after the 4th modwait fall.
- Sample flow: after load, push 16'h1234, 16'h0010, 16'h8000; model fir_out=sample+1, err=0. Expected:
  - Three data_ready transactions in FIFO order.
  - result_valid pulses with result 1235, 0011, 8001.
- FIFO full: stall modwait low-never-rising is avoided; instead hold modwait=1 long. Push DEPTH+1 samples -> sample_ready=0 after DEPTH pushes, the extra sample is not accepted, count stays DEPTH.
- Priority/pending: pulse new_coeff_set during an S_WAIT with 2 samples queued -> the current sample completes, then 4 coefficient loads occur, then the remaining samples are processed.
- Timeout: never raise modwait after data_ready -> after HS_TIMEOUT=16 cycles, data_ready=0, hs_timeout pulses once, no result_valid, FSM services the next queued sample.
